// File: rtl/hwpe_stream_tcdm_fetch.sv
// rtl/hwpe_stream_tcdm_fetch.sv - TCDM read fetcher feeding an in-order output stream
//
// Purpose: issues trans_size_i read requests to a TCDM port, pairs every in-order
// response with the byte strobe of its request, buffers the pairs in a DEPTH-entry
// FIFO and presents them on a valid/ready stream. A credit scheme (outstanding
// requests plus FIFO occupancy) keeps the FIFO from ever overflowing.
//
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   test_mode_i                    test mode, no functional effect
//   clear_i                        synchronous clear of all state
//   start_i, trans_size_i          start a transfer of trans_size_i words (IDLE only)
//   busy_o, done_o                 transfer in progress, one-cycle end-of-transfer pulse
//   addrgen_enable_o               advance the address generator (one pulse per grant)
//   gen_addr_i, gen_strb_i         address and strobe from the address generator
//   tcdm_req_o/gnt_i/add_o/be_o    TCDM request channel
//   tcdm_r_valid_i, tcdm_r_data_i  TCDM response channel
//   stream_valid_o/data_o/strb_o   output stream, handshake with stream_ready_i
//
// Configuration: define HWPE_STREAM_TCDM_FETCH_BYPASS_EN to forward a response
// straight to the stream in the same cycle when the FIFO is empty and the stream
// is ready. Without it every beat goes through the FIFO (one cycle minimum latency).

module hwpe_stream_tcdm_fetch #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    test_mode_i,
    input  logic                    clear_i,
    input  logic                    start_i,
    input  logic [31:0]             trans_size_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    addrgen_enable_o,
    input  logic [31:0]             gen_addr_i,
    input  logic [DATA_WIDTH/8-1:0] gen_strb_i,
    output logic                    tcdm_req_o,
    input  logic                    tcdm_gnt_i,
    output logic [31:0]             tcdm_add_o,
    output logic [DATA_WIDTH/8-1:0] tcdm_be_o,
    input  logic                    tcdm_r_valid_i,
    input  logic [DATA_WIDTH-1:0]   tcdm_r_data_i,
    output logic                    stream_valid_o,
    output logic [DATA_WIDTH-1:0]   stream_data_o,
    output logic [DATA_WIDTH/8-1:0] stream_strb_o,
    input  logic                    stream_ready_i
);

    localparam int unsigned BW = DATA_WIDTH / 8;
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_done;
    logic [31:0]           r_size;
    logic [31:0]           r_issued;
    logic [CW-1:0]         r_outstanding;
    logic [CW-1:0]         r_count;
    logic [PW-1:0]         r_sq_wr;
    logic [PW-1:0]         r_sq_rd;
    logic [PW-1:0]         r_fifo_wr;
    logic [PW-1:0]         r_fifo_rd;

    logic [BW-1:0]         r_sq_mem   [DEPTH];
    logic [DATA_WIDTH-1:0] r_fd_mem   [DEPTH];
    logic [BW-1:0]         r_fs_mem   [DEPTH];

    logic [CW:0]           w_credits;
    logic                  w_req;
    logic                  w_grant;
    logic                  w_resp;
    logic                  w_bypass;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_last_grant;
    logic                  w_drained;
    logic                  w_unused;

    assign w_unused = test_mode_i;

    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Every granted word is either outstanding or sitting in the FIFO, so
    // limiting their sum to DEPTH guarantees room for every response.
    assign w_credits    = {1'b0, r_outstanding} + {1'b0, r_count};
    assign w_req        = (r_state == S_RUN) && (w_credits < (CW+1)'(DEPTH));
    assign w_grant      = w_req && tcdm_gnt_i;

    // A response with nothing outstanding is stale (e.g. after a clear) and dropped.
    assign w_resp       = tcdm_r_valid_i && (r_outstanding != '0);

    assign w_empty      = (r_count == '0);
    assign w_full       = (r_count == CW'(DEPTH));

`ifdef HWPE_STREAM_TCDM_FETCH_BYPASS_EN
    assign w_bypass     = w_resp && w_empty && stream_ready_i;
`else
    assign w_bypass     = 1'b0;
`endif

    assign w_pop        = !w_empty && stream_ready_i;
    assign w_push       = w_resp && !w_bypass && (!w_full || w_pop);
    assign w_last_grant = w_grant && (r_issued == r_size - 32'd1);
    assign w_drained    = (r_outstanding == '0) && w_empty;

    assign tcdm_req_o       = w_req;
    assign tcdm_add_o       = gen_addr_i;
    assign tcdm_be_o        = gen_strb_i;
    assign addrgen_enable_o = w_grant;
    assign busy_o           = (r_state != S_IDLE);
    assign done_o           = r_done;

    assign stream_valid_o = w_bypass || !w_empty;
    assign stream_data_o  = w_bypass ? tcdm_r_data_i      : r_fd_mem[r_fifo_rd];
    assign stream_strb_o  = w_bypass ? r_sq_mem[r_sq_rd]  : r_fs_mem[r_fifo_rd];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state       <= S_IDLE;
            r_done        <= 1'b0;
            r_size        <= '0;
            r_issued      <= '0;
            r_outstanding <= '0;
            r_count       <= '0;
            r_sq_wr       <= '0;
            r_sq_rd       <= '0;
            r_fifo_wr     <= '0;
            r_fifo_rd     <= '0;
        end else if (clear_i) begin
            r_state       <= S_IDLE;
            r_done        <= 1'b0;
            r_size        <= '0;
            r_issued      <= '0;
            r_outstanding <= '0;
            r_count       <= '0;
            r_sq_wr       <= '0;
            r_sq_rd       <= '0;
            r_fifo_wr     <= '0;
            r_fifo_rd     <= '0;
        end else begin
            r_done <= 1'b0;

            if (w_grant) begin
                r_issued <= r_issued + 32'd1;
            end

            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        if (trans_size_i != 32'd0) begin
                            r_state  <= S_RUN;
                            r_size   <= trans_size_i;
                            r_issued <= '0;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (w_last_grant) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_drained) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // Strobe queue occupancy tracks outstanding exactly.
            if (w_grant && !w_resp) begin
                r_outstanding <= r_outstanding + CW'(1);
            end else if (!w_grant && w_resp) begin
                r_outstanding <= r_outstanding - CW'(1);
            end
            if (w_grant) begin
                r_sq_wr <= f_inc(r_sq_wr);
            end
            if (w_resp) begin
                r_sq_rd <= f_inc(r_sq_rd);
            end

            if (w_push) begin
                r_fifo_wr <= f_inc(r_fifo_wr);
            end
            if (w_pop) begin
                r_fifo_rd <= f_inc(r_fifo_rd);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Storage arrays carry no reset; validity comes from the pointers and counters.
    always_ff @(posedge clk_i) begin
        if (w_grant) begin
            r_sq_mem[r_sq_wr] <= gen_strb_i;
        end
        if (w_push) begin
            r_fd_mem[r_fifo_wr] <= tcdm_r_data_i;
            r_fs_mem[r_fifo_wr] <= r_sq_mem[r_sq_rd];
        end
    end

endmodule
